// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the RAM arbiter.
//   AW_DEF / DW_DEF : default address and data widths of the shared 64K x 16 RAM
//   owner_e         : which port owns the RAM in a given cycle. OWN_NONE doubles
//                     as the arbiter's IDLE state (no grant last cycle).
package mem_pkg;

  localparam int unsigned AW_DEF = 16;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a bounded burst lock.
//   clk, rst       : system clock; synchronous active-high reset
//   a_req, b_req   : requests from port A and port B
//   a_gnt, b_gnt   : one-hot (or zero) grant, combinational from req and state
// With both ports requesting, the port that owned the previous cycle keeps the
// RAM until it has had MAX_BURST consecutive grants, then the other port gets it.
// After an idle cycle the contest goes to the port that did not own the RAM last.
// FIXED_PRIO=1 turns this into plain A-over-B priority.
module rr_arb2
  import mem_pkg::*;
#(
  parameter int unsigned MAX_BURST  = 4,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  localparam int unsigned     CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   BURST_MAX = CW'(MAX_BURST);

  owner_e        state_q, state_d;          // owner of the previous cycle (IDLE = OWN_NONE)
  owner_e        last_owner_q, last_owner_d; // most recent non-idle owner
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  owner_e        grant;

  // Grant decision.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    grant = OWN_NONE;
    if (rst) begin
      grant = OWN_NONE;
    end else if (FIXED_PRIO != 1'b0) begin
      if (a_req)      grant = OWN_A;
      else if (b_req) grant = OWN_B;
    end else if (a_req && b_req) begin
      if (state_q == OWN_NONE) begin
        // Nobody streaming: hand the contest to the port that did not go last.
        grant = (last_owner_q == OWN_A) ? OWN_B : OWN_A;
      end else if (burst_cnt_q < BURST_MAX) begin
        grant = state_q;
      end else begin
        grant = (state_q == OWN_A) ? OWN_B : OWN_A;
      end
    end else if (a_req) begin
      grant = OWN_A;
    end else if (b_req) begin
      grant = OWN_B;
    end
  end

  assign a_gnt = (grant == OWN_A);
  assign b_gnt = (grant == OWN_B);

  // Next-state: state follows the grant every cycle.
  always_comb begin
    state_d      = grant;
    last_owner_d = (grant == OWN_NONE) ? last_owner_q : grant;
    burst_cnt_d  = '0;
    if ((FIXED_PRIO == 1'b0) && (grant != OWN_NONE)) begin
      if (grant == state_q) begin
        // Repeat grant: count up, saturating so a long solo stream can still
        // be interrupted the moment the other port asks.
        burst_cnt_d = (burst_cnt_q == BURST_MAX) ? BURST_MAX : burst_cnt_q + 1'b1;
      end else begin
        // Owner switch or first grant after idle starts a new burst.
        burst_cnt_d = CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OWN_NONE;
      last_owner_q <= OWN_B;     // so A wins the first contest after reset
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between port A (CPU)
// and port B (loader / DMA). One access per cycle; read data comes straight
// from the RAM's registered dout one cycle after the grant.
//   clk, rst                              : clock; synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata             : port A request, held until a_gnt
//   a_gnt                                 : port A access issued to RAM this cycle
//   a_rvalid                              : port A read data valid on rdata
//   b_*                                   : same for port B
//   rdata                                 : RAM dout passthrough
//   ram_addr/ram_din/ram_we               : to RAM
//   ram_dout                              : from RAM
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned MAX_BURST  = 4,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  logic [AW-1:0] last_addr_q, last_addr_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;

  rr_arb2 #(
    .MAX_BURST (MAX_BURST),
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .a_req(a_req),
    .b_req(b_req),
    .a_gnt(a_gnt),
    .b_gnt(b_gnt)
  );

  // RAM-side mux. Grants are already forced low during reset, so a write
  // presented in the reset cycle never reaches the RAM.
  always_comb begin
    ram_addr = last_addr_q;   // idle: hold the last issued address
    ram_din  = '0;
    ram_we   = 1'b0;
    if (a_gnt) begin
      ram_addr = a_addr;
      ram_din  = a_wdata;
      ram_we   = a_we;
    end else if (b_gnt) begin
      ram_addr = b_addr;
      ram_din  = b_wdata;
      ram_we   = b_we;
    end
    last_addr_d = ram_addr;
    a_rvalid_d  = a_gnt && !a_we;
    b_rvalid_d  = b_gnt && !b_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr_q <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
    end else begin
      last_addr_q <= last_addr_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
    end
  end

  // A read granted the cycle before reset must not report valid while reset
  // is asserted, so the registered valids are also gated by rst.
  assign a_rvalid = a_rvalid_q && !rst;
  assign b_rvalid = b_rvalid_q && !rst;
  assign rdata    = ram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. A behavioural RAM sits
// beside the DUT; a reference model (grant history + memory array) predicts
// grants and read data, read expectations are queued and retired by a
// separate monitor when the DUT raises a_rvalid/b_rvalid.
module tb_mem_arbiter;

  localparam int MAX_BURST = 4;

  typedef struct {
    bit          req;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } preq_t;

  typedef struct {
    int          port;   // 1 = A, 2 = B
    int          due;    // cycle in which rvalid must be seen
    logic [15:0] data;
  } rd_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (round-robin) ----------------
  logic        rst = 1'b1;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [15:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we;
  logic [15:0] rdata, ram_addr, ram_din, ram_dout;

  mem_arbiter #(.AW(16), .DW(16), .MAX_BURST(MAX_BURST), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  // Behavioural single-port RAM with registered dout.
  logic [15:0] ram_mem [0:65535];
  initial for (int i = 0; i < 65536; i++) ram_mem[i] = 16'h0000;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  // ---------------- fixed-priority DUT ----------------
  logic        f_rst = 1'b1;
  logic        f_a_req = 0, f_b_req = 0;
  logic        f_a_gnt, f_a_rvalid, f_b_gnt, f_b_rvalid, f_ram_we;
  logic [15:0] f_rdata, f_ram_addr, f_ram_din;
  logic [15:0] f_ram_dout;
  logic [15:0] f_zero16 = 16'h0000;
  logic        f_zero1  = 1'b0;
  assign f_ram_dout = 16'h0000;

  mem_arbiter #(.AW(16), .DW(16), .MAX_BURST(MAX_BURST), .FIXED_PRIO(1'b1)) dut_fixed (
    .clk(clk), .rst(f_rst),
    .a_req(f_a_req), .a_we(f_zero1), .a_addr(f_zero16), .a_wdata(f_zero16),
    .a_gnt(f_a_gnt), .a_rvalid(f_a_rvalid),
    .b_req(f_b_req), .b_we(f_zero1), .b_addr(f_zero16), .b_wdata(f_zero16),
    .b_gnt(f_b_gnt), .b_rvalid(f_b_rvalid),
    .rdata(f_rdata), .ram_addr(f_ram_addr), .ram_din(f_ram_din), .ram_we(f_ram_we),
    .ram_dout(f_ram_dout)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [int];
  int          grant_hist[$];    // 0 none, 1 A, 2 B, one entry per cycle since reset
  rd_exp_t     exp_q[$];
  logic [15:0] last_addr;
  bit          last_addr_ok = 0;

  function automatic logic [15:0] ref_read(input logic [15:0] addr);
    return ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 16'h0000;
  endfunction

  // Who should win this cycle, from the rules: lone requester wins; a contest
  // after idle goes to whoever did not own the RAM last (B counts as last after
  // reset); otherwise the current owner keeps it until its run reaches MAX_BURST.
  function automatic int predict(input bit ar, input bit br);
    int prev, run, last;
    if (!ar && !br) return 0;
    if (ar && !br)  return 1;
    if (br && !ar)  return 2;
    prev = (grant_hist.size() == 0) ? 0 : grant_hist[grant_hist.size()-1];
    if (prev == 0) begin
      last = 2;
      for (int i = grant_hist.size()-1; i >= 0; i--)
        if (grant_hist[i] != 0) begin last = grant_hist[i]; break; end
      return (last == 1) ? 2 : 1;
    end
    run = 0;
    for (int i = grant_hist.size()-1; i >= 0; i--) begin
      if (grant_hist[i] != prev) break;
      run++;
    end
    return (run < MAX_BURST) ? prev : 3 - prev;
  endfunction

  function automatic preq_t mk(input bit req, input bit we, input logic [15:0] addr,
                               input logic [15:0] wdata);
    preq_t p;
    p.req = req; p.we = we; p.addr = addr; p.wdata = wdata;
    return p;
  endfunction

  // One bus cycle: drive, check grant/RAM side at negedge, update model.
  task automatic step(input bit r, input preq_t pa, input preq_t pb,
                      output int g_exp, output int g_obs,
                      output bit arv, output bit brv, output logic [15:0] rd);
    preq_t w;
    rst = r;
    a_req = pa.req; a_we = pa.we; a_addr = pa.addr; a_wdata = pa.wdata;
    b_req = pb.req; b_we = pb.we; b_addr = pb.addr; b_wdata = pb.wdata;
    @(negedge clk);
    g_obs = (a_gnt === 1'b1 && b_gnt === 1'b1) ? 3 :
            (a_gnt === 1'b1) ? 1 : (b_gnt === 1'b1) ? 2 : 0;
    arv = a_rvalid; brv = b_rvalid; rd = rdata;
    if (r) begin
      g_exp = 0;
      check("rst_grant", g_obs, 0);
      check("rst_ram_we", ram_we, 0);
      grant_hist.delete();
      last_addr_ok = 0;
    end else begin
      g_exp = predict(pa.req, pb.req);
      check("grant", g_obs, g_exp);
      if (g_exp != 0) begin
        w = (g_exp == 1) ? pa : pb;
        check("ram_addr", ram_addr, w.addr);
        check("ram_we", ram_we, w.we);
        if (w.we) begin
          check("ram_din", ram_din, w.wdata);
          ref_mem[int'(w.addr)] = w.wdata;
        end else begin
          exp_q.push_back('{port: g_exp, due: cyc + 1, data: ref_read(w.addr)});
        end
        last_addr = w.addr;
        last_addr_ok = 1;
      end else begin
        check("idle_ram_we", ram_we, 0);
        if (last_addr_ok) check("idle_ram_addr", ram_addr, last_addr);
      end
      grant_hist.push_back(g_exp);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  rd_exp_t mon_e;
  bit      mon_ea, mon_eb;
  always @(negedge clk) begin
    mon_ea = 0; mon_eb = 0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      if (!rst) begin     // reset suppresses a pending read response
        mon_ea = (mon_e.port == 1);
        mon_eb = (mon_e.port == 2);
      end
    end
    check("a_rvalid", a_rvalid, mon_ea);
    check("b_rvalid", b_rvalid, mon_eb);
    if (mon_ea || mon_eb) check("rdata", rdata, mon_e.data);
  end

  // Watchdog: the run is step-bounded, this only guards against a stuck sim.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    preq_t idle, pa, pb;
    int    ge, go;
    bit    arv, brv;
    logic [15:0] rd;
    bit    pend_a, pend_b;

    idle = mk(0, 0, 16'h0, 16'h0);
    #1;

    // 1: reset held with both requesting, then A wins the first contest.
    for (int i = 0; i < 3; i++)
      step(1, mk(1, 1, 16'h0001, 16'hAAAA), mk(1, 1, 16'h0002, 16'hBBBB), ge, go, arv, brv, rd);
    step(0, mk(1, 0, 16'h0001, 0), mk(1, 0, 16'h0002, 0), ge, go, arv, brv, rd);
    check("t1_first_winner_A", go, 1);
    step(0, idle, mk(1, 0, 16'h0002, 0), ge, go, arv, brv, rd);

    // 2: A writes 0x1234 @0x0020, reads it back next cycle.
    step(0, mk(1, 1, 16'h0020, 16'h1234), idle, ge, go, arv, brv, rd);
    step(0, mk(1, 0, 16'h0020, 0), idle, ge, go, arv, brv, rd);
    step(0, idle, idle, ge, go, arv, brv, rd);
    check("t2_a_rvalid", arv, 1);
    check("t2_rdata", rd, 16'h1234);

    // 3: both stream reads from reset; grants alternate in runs of MAX_BURST.
    step(1, idle, idle, ge, go, arv, brv, rd);
    for (int i = 0; i < 16; i++) begin
      step(0, mk(1, 0, 16'h0020, 0), mk(1, 0, 16'h0030, 0), ge, go, arv, brv, rd);
      check("t3_burst_pattern", go, ((i / MAX_BURST) % 2 == 0) ? 1 : 2);
    end

    // 4: A alone, B alone, idle, then both -> A (B owned last).
    step(0, mk(1, 0, 16'h0003, 0), idle, ge, go, arv, brv, rd);
    step(0, idle, mk(1, 0, 16'h0004, 0), ge, go, arv, brv, rd);
    step(0, idle, idle, ge, go, arv, brv, rd);
    step(0, mk(1, 0, 16'h0005, 0), mk(1, 0, 16'h0006, 0), ge, go, arv, brv, rd);
    check("t4_contest_after_idle", go, 1);
    step(0, idle, mk(1, 0, 16'h0006, 0), ge, go, arv, brv, rd);

    // 5: B writes 0xBEEF @0x0040, A reads 0x0040 the next cycle.
    step(0, idle, mk(1, 1, 16'h0040, 16'hBEEF), ge, go, arv, brv, rd);
    step(0, mk(1, 0, 16'h0040, 0), idle, ge, go, arv, brv, rd);
    step(0, idle, idle, ge, go, arv, brv, rd);
    check("t5_a_rvalid", arv, 1);
    check("t5_rdata", rd, 16'hBEEF);

    // 6a: reset the cycle after a B read grant -> no b_rvalid.
    step(0, idle, mk(1, 0, 16'h0040, 0), ge, go, arv, brv, rd);
    step(1, mk(1, 1, 16'h0041, 16'h5555), idle, ge, go, arv, brv, rd);
    check("t6_b_rvalid_suppressed", brv, 0);
    step(0, idle, idle, ge, go, arv, brv, rd);
    check("t6_no_late_rvalid", brv, 0);

    // Randomized traffic: requests held until granted, occasional reset.
    pend_a = 0; pend_b = 0; pa = idle; pb = idle;
    for (int i = 0; i < 400; i++) begin
      if (!pend_a && $urandom_range(0, 99) < 65) begin
        pa = mk(1, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 15)), 16'($urandom));
        pend_a = 1;
      end
      if (!pend_b && $urandom_range(0, 99) < 65) begin
        pb = mk(1, $urandom_range(0, 2) == 0, 16'($urandom_range(0, 15)), 16'($urandom));
        pend_b = 1;
      end
      step($urandom_range(0, 99) < 2, pend_a ? pa : idle, pend_b ? pb : idle,
           ge, go, arv, brv, rd);
      if (ge == 1) pend_a = 0;
      if (ge == 2) pend_b = 0;
    end
    step(0, idle, idle, ge, go, arv, brv, rd);
    step(0, idle, idle, ge, go, arv, brv, rd);

    // 6b: fixed priority -> B starved while A requests, served once A drops.
    rst = 1;
    f_rst = 1;
    @(posedge clk); #1;
    f_rst = 0; f_a_req = 1; f_b_req = 1;
    for (int i = 0; i < 2 * MAX_BURST + 2; i++) begin
      @(negedge clk);
      check("fixed_a_gnt", f_a_gnt, 1);
      check("fixed_b_starved", f_b_gnt, 0);
      @(posedge clk); #1;
    end
    f_a_req = 0;
    @(negedge clk);
    check("fixed_b_served", f_b_gnt, 1);
    check("fixed_a_idle", f_a_gnt, 0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
